// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between CHANNELS requesters using
// fixed or round-robin arbitration and a per-channel req/ack handshake.
module sram_arbiter #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned RR_MODE       = 1,
    parameter int unsigned PRIO0         = 1
) (
    input  logic                       clk28,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        req,
    input  logic [CHANNELS-1:0]        we,
    input  logic [CHANNELS*ADDR_W-1:0] addr,
    input  logic [CHANNELS*DATA_W-1:0] wdata,
    output logic [CHANNELS-1:0]        ack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic [ADDR_W-1:0]          va,
    output logic [DATA_W-1:0]          vd_out,
    output logic                       vd_oe,
    input  logic [DATA_W-1:0]          vd_in,
    output logic                       n_vrd,
    output logic                       n_vwr
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam int unsigned IDX_W = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   gnt;
    logic               wr;

    logic               grant_c;
    logic               prio_hit_c;
    logic [IDX_W-1:0]   win_c;
    int                 scan_idx;
    logic [ADDR_W-1:0]  addr_sel_c;
    logic [DATA_W-1:0]  wdata_sel_c;
    logic               we_sel_c;

    // Winner selection; the round-robin scan wraps explicitly so that
    // non-power-of-two channel counts never index past CHANNELS-1.
    always_comb begin
        grant_c    = 1'b0;
        win_c      = '0;
        scan_idx   = 0;
        prio_hit_c = (PRIO0 != 0) && req[0];
        if (prio_hit_c) begin
            grant_c = 1'b1;
        end else if (RR_MODE != 0) begin
            for (int k = 1; k <= int'(CHANNELS); k++) begin
                scan_idx = int'(last) + k;
                if (scan_idx >= int'(CHANNELS)) begin
                    scan_idx = scan_idx - int'(CHANNELS);
                end
                if (!grant_c && req[IDX_W'(scan_idx)]) begin
                    grant_c = 1'b1;
                    win_c   = IDX_W'(scan_idx);
                end
            end
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (!grant_c && req[IDX_W'(i)]) begin
                    grant_c = 1'b1;
                    win_c   = IDX_W'(i);
                end
            end
        end
    end

    // Payload of the winning channel
    always_comb begin
        addr_sel_c  = '0;
        wdata_sel_c = '0;
        we_sel_c    = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (win_c == IDX_W'(i)) begin
                addr_sel_c  = addr[i*ADDR_W +: ADDR_W];
                wdata_sel_c = wdata[i*DATA_W +: DATA_W];
                we_sel_c    = we[IDX_W'(i)];
            end
        end
    end

    // Access sequencer; every SRAM pin comes straight from a flop.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= IDX_W'(CHANNELS - 1);
            gnt    <= '0;
            wr     <= 1'b0;
            ack    <= '0;
            rdata  <= '0;
            busy   <= 1'b0;
            va     <= '0;
            vd_out <= '0;
            vd_oe  <= 1'b0;
            n_vrd  <= 1'b1;
            n_vwr  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        gnt    <= win_c;
                        if (!prio_hit_c) begin
                            last <= win_c;
                        end
                        wr     <= we_sel_c;
                        va     <= addr_sel_c;
                        vd_out <= wdata_sel_c;
                        vd_oe  <= we_sel_c;
                        n_vrd  <= we_sel_c;
                        n_vwr  <= !we_sel_c;
                        cnt    <= CNT_W'(ACCESS_CYCLES - 1);
                        busy   <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!wr) begin
                            rdata <= vd_in;
                        end
                        n_vrd <= 1'b1;
                        n_vwr <= 1'b1;
                        ack   <= CHANNELS'(1) << gnt;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    ack   <= '0;
                    vd_oe <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: three instances cover round-robin,
// channel-0 priority and fixed-priority configurations.
module tb_sram_arbiter;

    localparam int unsigned CH = 4;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 8;

    logic              clk28;
    logic              rst;
    logic [CH-1:0]     req   [3];
    logic [CH-1:0]     we    [3];
    logic [CH-1:0]     ack   [3];
    logic [CH*AW-1:0]  addr  [3];
    logic [CH*DW-1:0]  wdata [3];
    logic [DW-1:0]     rdata [3];
    logic [DW-1:0]     vd_out[3];
    logic [DW-1:0]     vd_in [3];
    logic [AW-1:0]     va    [3];
    logic              busy  [3];
    logic              vd_oe [3];
    logic              n_vrd [3];
    logic              n_vwr [3];

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2),
                   .RR_MODE(1), .PRIO0(0)) u_rr (
        .clk28(clk28), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]),
        .va(va[0]), .vd_out(vd_out[0]), .vd_oe(vd_oe[0]), .vd_in(vd_in[0]),
        .n_vrd(n_vrd[0]), .n_vwr(n_vwr[0]));

    sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2),
                   .RR_MODE(1), .PRIO0(1)) u_prio (
        .clk28(clk28), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]),
        .va(va[1]), .vd_out(vd_out[1]), .vd_oe(vd_oe[1]), .vd_in(vd_in[1]),
        .n_vrd(n_vrd[1]), .n_vwr(n_vwr[1]));

    sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2),
                   .RR_MODE(0), .PRIO0(0)) u_fixed (
        .clk28(clk28), .rst(rst), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]),
        .va(va[2]), .vd_out(vd_out[2]), .vd_oe(vd_oe[2]), .vd_in(vd_in[2]),
        .n_vrd(n_vrd[2]), .n_vwr(n_vwr[2]));

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    // Strobe exclusivity and no data drive during a read, on every instance
    always @(negedge clk28) begin
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!n_vrd[i] && !n_vwr[i]) begin
                errors++;
                $display("FAIL strobes_both_low inst%0d: n_vrd=%b n_vwr=%b required not both 0", i, n_vrd[i], n_vwr[i]);
            end
            checks++;
            if (!n_vrd[i] && vd_oe[i]) begin
                errors++;
                $display("FAIL oe_during_read inst%0d: vd_oe=%b required 0 while n_vrd=0", i, vd_oe[i]);
            end
        end
    end

    task automatic clear_inputs;
        for (int i = 0; i < 3; i++) begin
            req[i]   = '0;
            we[i]    = '0;
            addr[i]  = '0;
            wdata[i] = '0;
            vd_in[i] = '0;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk28); #1;
        rst = 1'b0;
        @(posedge clk28); #1;
    endtask

    // Waits (bounded) for the next ack on one instance; a=0 means timeout
    task automatic wait_ack(input int inst, output logic [CH-1:0] a, output int cyc);
        a   = '0;
        cyc = 0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk28); #1;
            if (ack[inst] != '0) begin
                a   = ack[inst];
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ack[i], busy[i], vd_oe[i], n_vrd[i], n_vwr[i]} !== 8'b0000_0011) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: {ack,busy,oe,nrd,nwr}=%b required 00000011", i,
                         {ack[i], busy[i], vd_oe[i], n_vrd[i], n_vwr[i]});
            end
            checks++;
            if ({va[i], vd_out[i], rdata[i]} !== '0) begin
                errors++;
                $display("FAIL reset_data inst%0d: va=%h vd_out=%h rdata=%h required 0", i, va[i], vd_out[i], rdata[i]);
            end
        end
        @(posedge clk28); #1;
        rst = 1'b0;
        @(posedge clk28); #1;
    endtask

    task automatic test_single_read;
        logic           exp_nrd;
        logic [CH-1:0]  exp_ack;
        do_reset();
        vd_in[0]         = 8'hA5;
        addr[0][AW +: AW] = 19'h1C000;
        req[0]           = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk28); #1;
            exp_nrd = !(c == 1 || c == 2);
            exp_ack = (c == 3) ? 4'b0010 : 4'b0000;
            checks++;
            if (n_vrd[0] !== exp_nrd) begin
                errors++;
                $display("FAIL read_nvrd c%0d: n_vrd=%b required %b", c, n_vrd[0], exp_nrd);
            end
            checks++;
            if (busy[0] !== (c <= 3)) begin
                errors++;
                $display("FAIL read_busy c%0d: busy=%b required %b", c, busy[0], (c <= 3));
            end
            checks++;
            if (ack[0] !== exp_ack) begin
                errors++;
                $display("FAIL read_ack c%0d: ack=%b required %b", c, ack[0], exp_ack);
            end
            if (c <= 2) begin
                checks++;
                if (va[0] !== 19'h1C000) begin
                    errors++;
                    $display("FAIL read_va c%0d: va=%h required 1c000", c, va[0]);
                end
            end
            if (c == 3) begin
                checks++;
                if (rdata[0] !== 8'hA5) begin
                    errors++;
                    $display("FAIL read_rdata: rdata=%h required a5", rdata[0]);
                end
                req[0] = '0;
            end
        end
    endtask

    task automatic test_write;
        logic           exp_nwr;
        logic           exp_oe;
        logic [CH-1:0]  exp_ack;
        do_reset();
        addr[0][2*AW +: AW]  = 19'h7FFFF;
        wdata[0][2*DW +: DW] = 8'h3C;
        we[0]                = 4'b0100;
        req[0]               = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk28); #1;
            exp_nwr = !(c == 1 || c == 2);
            exp_oe  = (c <= 3);
            exp_ack = (c == 3) ? 4'b0100 : 4'b0000;
            checks++;
            if (n_vwr[0] !== exp_nwr) begin
                errors++;
                $display("FAIL write_nvwr c%0d: n_vwr=%b required %b", c, n_vwr[0], exp_nwr);
            end
            checks++;
            if (vd_oe[0] !== exp_oe) begin
                errors++;
                $display("FAIL write_oe c%0d: vd_oe=%b required %b", c, vd_oe[0], exp_oe);
            end
            checks++;
            if (n_vrd[0] !== 1'b1) begin
                errors++;
                $display("FAIL write_nvrd c%0d: n_vrd=%b required 1", c, n_vrd[0]);
            end
            checks++;
            if (ack[0] !== exp_ack) begin
                errors++;
                $display("FAIL write_ack c%0d: ack=%b required %b", c, ack[0], exp_ack);
            end
            if (c <= 3) begin
                checks++;
                if ({va[0], vd_out[0]} !== {19'h7FFFF, 8'h3C}) begin
                    errors++;
                    $display("FAIL write_bus c%0d: va=%h vd_out=%h required 7ffff/3c", c, va[0], vd_out[0]);
                end
            end
            if (c == 3) begin
                req[0] = '0;
                we[0]  = '0;
            end
        end
    endtask

    task automatic test_round_robin;
        logic [CH-1:0] exp_ack;
        do_reset();
        req[0] = 4'b1111;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk28); #1;
            exp_ack = ((c % 4) == 3) ? (4'b0001 << (((c - 3) / 4) % 4)) : 4'b0000;
            checks++;
            if (ack[0] !== exp_ack) begin
                errors++;
                $display("FAIL rr_ack c%0d: ack=%b required %b", c, ack[0], exp_ack);
            end
        end
        req[0] = '0;
    endtask

    task automatic test_prio0;
        logic [CH-1:0] a;
        int            cyc;
        do_reset();
        req[1] = 4'b0100;
        wait_ack(1, a, cyc);
        checks++;
        if (a !== 4'b0100) begin
            errors++;
            $display("FAIL prio_first: ack=%b required 0100", a);
        end
        req[1] = 4'b1011;
        for (int n = 0; n < 3; n++) begin
            wait_ack(1, a, cyc);
            checks++;
            if ({a, 8'(cyc)} !== {4'b0001, 8'd4}) begin
                errors++;
                $display("FAIL prio_ch0 n%0d: ack=%b gap=%0d required 0001 gap 4", n, a, cyc);
            end
        end
        req[1] = 4'b1010;
        wait_ack(1, a, cyc);
        checks++;
        if (a !== 4'b1000) begin
            errors++;
            $display("FAIL prio_last_kept: ack=%b required 1000", a);
        end
        req[1] = 4'b0010;
        wait_ack(1, a, cyc);
        checks++;
        if (a !== 4'b0010) begin
            errors++;
            $display("FAIL prio_after: ack=%b required 0010", a);
        end
        req[1] = '0;
    endtask

    task automatic test_fixed;
        logic [CH-1:0] a;
        int            cyc;
        do_reset();
        req[2] = 4'b0110;
        wait_ack(2, a, cyc);
        checks++;
        if ({a, 8'(cyc)} !== {4'b0010, 8'd3}) begin
            errors++;
            $display("FAIL fixed_first: ack=%b lat=%0d required 0010 lat 3", a, cyc);
        end
        req[2] = 4'b0100;
        wait_ack(2, a, cyc);
        checks++;
        if ({a, 8'(cyc)} !== {4'b0100, 8'd4}) begin
            errors++;
            $display("FAIL fixed_second: ack=%b gap=%0d required 0100 gap 4", a, cyc);
        end
        req[2] = '0;
    endtask

    task automatic test_reset_mid_access;
        logic [CH-1:0] a;
        int            cyc;
        do_reset();
        vd_in[0] = 8'hA5;
        req[0]   = 4'b0010;
        wait_ack(0, a, cyc);
        req[0] = '0;
        checks++;
        if ({a, rdata[0]} !== {4'b0010, 8'hA5}) begin
            errors++;
            $display("FAIL mid_prep: ack=%b rdata=%h required 0010/a5", a, rdata[0]);
        end
        @(posedge clk28); #1;
        req[0] = 4'b0001;
        @(posedge clk28); #1;
        checks++;
        if (n_vrd[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_strobe: n_vrd=%b required 0", n_vrd[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({n_vrd[0], busy[0], ack[0], rdata[0]} !== {1'b1, 1'b0, 4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL mid_async: n_vrd=%b busy=%b ack=%b rdata=%h required 1/0/0000/00",
                     n_vrd[0], busy[0], ack[0], rdata[0]);
        end
        @(posedge clk28); #1;
        checks++;
        if (ack[0] !== 4'b0000) begin
            errors++;
            $display("FAIL mid_noack: ack=%b required 0000", ack[0]);
        end
        req[0] = 4'b0110;
        rst    = 1'b0;
        wait_ack(0, a, cyc);
        checks++;
        if ({a, 8'(cyc)} !== {4'b0010, 8'd3}) begin
            errors++;
            $display("FAIL mid_resume: ack=%b lat=%0d required 0010 lat 3", a, cyc);
        end
        req[0] = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_prio0();
        test_fixed();
        test_reset_mid_access();
        repeat (2) @(posedge clk28);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
